// File: rtl/service_2_countdown_pkg.sv
// Shared types and constants for the MM:SS countdown service.
// The optional alarm blink feature is selected by SERVICE2_ALARM_BLINK_EN.
package service_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAUSE = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SEL_ALL  = 4'b1111;
  localparam logic [3:0] SEL_NONE = 4'b0000;

  localparam int DIG_W = 4;
  localparam int MIN_T = 12;
  localparam int MIN_O = 8;
  localparam int SEC_T = 4;
  localparam int SEC_O = 0;

  // One digit of the borrow chain: returns {new_digit, borrow_out}.
  function automatic logic [DIG_W:0] dig_dec(input logic [DIG_W-1:0] d,
                                             input logic [DIG_W-1:0] wrap,
                                             input logic             bin);
    if (!bin) return {d, 1'b0};
    if (d == '0) return {wrap, 1'b1};
    return {d - 1'b1, 1'b0};
  endfunction

endpackage

// File: rtl/service_2_countdown_sec_tick_gen.sv
// One-second prescaler: tick on the last count of each second, half_tick on
// both the mid-second and last counts.
module sec_tick_gen #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int CNT_W         = 27
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic half_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(TICKS_PER_SEC / 2 - 1);

  logic [CNT_W-1:0] cnt;

  assign tick      = en & (cnt == LAST);
  assign half_tick = en & ((cnt == HALF) | (cnt == LAST));

  always_ff @(posedge clk) begin
    if (!resetn || clr) cnt <= '0;
    else if (tick)      cnt <= '0;
    else if (en)        cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/service_2_countdown.sv
// Latches a BCD MM:SS value from the time-set service and counts it down once
// per second; define SERVICE2_ALARM_BLINK_EN to blink the digits while in DONE.
module service_2_countdown
  import service_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int CNT_W         = 27
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [15:0] time_in,
  input  logic        spdt2,
  input  logic        push_c,
  output logic [15:0] num,
  output logic [3:0]  sel,
  output logic        running,
  output logic        done
);

  state_t      state, state_d;
  logic        load_q, armed, load_rise;
  logic        tick, half_tick, tick_en, tick_clr;
  logic [15:0] num_dec, num_d;
  logic [3:0]  sel_d;

  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    logic        b;
    r = t;
    {r[SEC_O +: DIG_W], b} = dig_dec(t[SEC_O +: DIG_W], 4'd9, 1'b1);
    {r[SEC_T +: DIG_W], b} = dig_dec(t[SEC_T +: DIG_W], 4'd5, b);
    {r[MIN_O +: DIG_W], b} = dig_dec(t[MIN_O +: DIG_W], 4'd9, b);
    {r[MIN_T +: DIG_W], b} = dig_dec(t[MIN_T +: DIG_W], 4'd9, b);
    return r;
  endfunction

  assign num_dec = bcd_dec(num);

  // Interface: load is a level whose rising edge requests a load, honoured
  // only in IDLE and never queued; a level already high across reset must
  // fall before it can request again. push_c is a one-cycle pulse that
  // cancels in RUN/PAUSE and acknowledges in DONE. No back-pressure exists.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      load_q <= 1'b0;
      armed  <= ~load;
    end else begin
      load_q <= load;
      armed  <= armed | ~load;
    end
  end

  assign load_rise = load & ~load_q & armed;

`ifdef SERVICE2_ALARM_BLINK_EN
  assign tick_en = ~push_c & (((state == RUN) & spdt2) | (state == DONE));
`else
  assign tick_en = ~push_c & (state == RUN) & spdt2;
`endif
  assign tick_clr = (state == IDLE);

  sec_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .CNT_W        (CNT_W)
  ) u_tick (
    .clk      (clk),
    .resetn   (resetn),
    .en       (tick_en),
    .clr      (tick_clr),
    .tick     (tick),
    .half_tick(half_tick)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (load_rise) state_d = (time_in == '0) ? DONE : (spdt2 ? RUN : PAUSE);
      PAUSE:   if (push_c) state_d = IDLE; else if (spdt2) state_d = RUN;
      RUN: begin
        if (push_c)                     state_d = IDLE;
        else if (!spdt2)                state_d = PAUSE;
        else if (tick && num_dec == '0) state_d = DONE;
      end
      DONE:    if (push_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Cancel wins over a coincident tick, so num_d never sees the decrement.
  always_comb begin
    num_d = num;
    sel_d = sel;
    case (state)
      IDLE: if (load_rise) begin
        num_d = time_in;
        sel_d = SEL_ALL;
      end
      PAUSE, RUN: begin
        if (push_c) begin
          num_d = '0;
          sel_d = SEL_NONE;
        end else if (state == RUN && tick) begin
          num_d = num_dec;
        end
      end
      DONE: begin
        if (push_c) begin
          num_d = '0;
          sel_d = SEL_NONE;
        end else if (half_tick) begin
          sel_d = ~sel;
        end
      end
      default: begin
        num_d = '0;
        sel_d = SEL_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      num     <= '0;
      sel     <= SEL_NONE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      num     <= num_d;
      sel     <= sel_d;
      running <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_service_2_countdown.sv
// Bench for service_2_countdown with a one-second period of 4 clocks; random
// runs are checked against a seconds-based model of the countdown.
module tb_service_2_countdown;

  localparam int TPS = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        load = 1'b0;
  logic [15:0] time_in = '0;
  logic        spdt2 = 1'b0;
  logic        push_c = 1'b0;
  logic [15:0] num;
  logic [3:0]  sel;
  logic        running, done;

  int tests = 0;
  int fails = 0;
  logic [21:0] exp_q[$];

  always #5 clk = ~clk;

  service_2_countdown #(.TICKS_PER_SEC(TPS), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn), .load(load), .time_in(time_in),
    .spdt2(spdt2), .push_c(push_c), .num(num), .sel(sel),
    .running(running), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_time(input logic [15:0] t, input logic sw);
    load = 1'b0;
    step();
    time_in = t;
    spdt2 = sw;
    load = 1'b1;
    step();
  endtask

  task automatic cancel();
    push_c = 1'b1;
    step();
    push_c = 1'b0;
    load = 1'b0;
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int m, ss;
    m = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Expected digit mask j clocks after entering DONE.
  function automatic logic [3:0] done_sel(input int j);
`ifdef SERVICE2_ALARM_BLINK_EN
    return (((j / 2) % 2) == 0) ? 4'hF : 4'h0;
`else
    return (j >= 0) ? 4'hF : 4'hF;
`endif
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    load = 1'b0;
    repeat (2) step();
    tests++;
    if ({num, sel, running, done} !== 22'h0) begin
      fails++; $display("FAIL reset got %h want %h", {num, sel, running, done}, 22'h0);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_countdown();
    logic [21:0] e;
    load_time(16'h0003, 1'b1);
    e = {16'h0003, 4'hF, 1'b1, 1'b0};
    tests++;
    if ({num, sel, running, done} !== e) begin
      fails++; $display("FAIL cd_load got %h want %h", {num, sel, running, done}, e);
    end
    for (int k = 1; k <= 3; k++) begin
      repeat (3) step();
      e = {16'(4 - k), 4'hF, 1'b1, 1'b0};
      tests++;
      if ({num, sel, running, done} !== e) begin
        fails++; $display("FAIL cd_hold%0d got %h want %h", k, {num, sel, running, done}, e);
      end
      step();
      e = (k < 3) ? {16'(3 - k), 4'hF, 1'b1, 1'b0} : {16'h0, 4'hF, 1'b0, 1'b1};
      tests++;
      if ({num, sel, running, done} !== e) begin
        fails++; $display("FAIL cd_tick%0d got %h want %h", k, {num, sel, running, done}, e);
      end
    end
    for (int j = 1; j <= 4; j++) begin
      step();
      e = {16'h0, done_sel(j), 1'b0, 1'b1};
      tests++;
      if ({num, sel, running, done} !== e) begin
        fails++; $display("FAIL cd_done%0d got %h want %h", j, {num, sel, running, done}, e);
      end
    end
    cancel();
    tests++;
    if ({num, sel, running, done} !== 22'h0) begin
      fails++; $display("FAIL cd_ack got %h want %h", {num, sel, running, done}, 22'h0);
    end
  endtask

  task automatic test_borrow();
    logic [15:0] ins[5];
    logic [15:0] outs[5];
    logic [21:0] e;
    ins  = '{16'h0100, 16'h1000, 16'h0175, 16'h000A, 16'h0170};
    outs = '{16'h0059, 16'h0959, 16'h0174, 16'h0009, 16'h0169};
    for (int i = 0; i < 5; i++) begin
      load_time(ins[i], 1'b1);
      repeat (3) step();
      e = {ins[i], 4'hF, 1'b1, 1'b0};
      tests++;
      if ({num, sel, running, done} !== e) begin
        fails++; $display("FAIL borrow_pre%0d got %h want %h", i, {num, sel, running, done}, e);
      end
      step();
      e = {outs[i], 4'hF, 1'b1, 1'b0};
      tests++;
      if ({num, sel, running, done} !== e) begin
        fails++; $display("FAIL borrow%0d got %h want %h", i, {num, sel, running, done}, e);
      end
      cancel();
      tests++;
      if ({num, sel, running, done} !== 22'h0) begin
        fails++; $display("FAIL borrow_cancel%0d got %h want %h", i, {num, sel, running, done}, 22'h0);
      end
    end
  endtask

  task automatic test_pause();
    logic [21:0] e;
    load_time(16'h0005, 1'b1);
    repeat (2) step();
    spdt2 = 1'b0;
    e = {16'h0005, 4'hF, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if ({num, sel, running, done} !== e) begin
        fails++; $display("FAIL pause%0d got %h want %h", i, {num, sel, running, done}, e);
      end
    end
    spdt2 = 1'b1;
    e = {16'h0005, 4'hF, 1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if ({num, sel, running, done} !== e) begin
        fails++; $display("FAIL resume%0d got %h want %h", i, {num, sel, running, done}, e);
      end
    end
    step();
    e = {16'h0004, 4'hF, 1'b1, 1'b0};
    tests++;
    if ({num, sel, running, done} !== e) begin
      fails++; $display("FAIL resume_tick got %h want %h", {num, sel, running, done}, e);
    end
    cancel();
  endtask

  task automatic test_cancel_tick();
    logic [21:0] e;
    load_time(16'h0009, 1'b1);
    repeat (3) step();
    e = {16'h0009, 4'hF, 1'b1, 1'b0};
    tests++;
    if ({num, sel, running, done} !== e) begin
      fails++; $display("FAIL ct_pre got %h want %h", {num, sel, running, done}, e);
    end
    push_c = 1'b1;
    step();
    push_c = 1'b0;
    tests++;
    if ({num, sel, running, done} !== 22'h0) begin
      fails++; $display("FAIL cancel_tick got %h want %h", {num, sel, running, done}, 22'h0);
    end
    repeat (4) step();
    push_c = 1'b1;
    step();
    push_c = 1'b0;
    tests++;
    if ({num, sel, running, done} !== 22'h0) begin
      fails++; $display("FAIL idle_push got %h want %h", {num, sel, running, done}, 22'h0);
    end
    load = 1'b0;
  endtask

  task automatic test_zero_load();
    logic [21:0] e;
    load_time(16'h0000, 1'b1);
    e = {16'h0, 4'hF, 1'b0, 1'b1};
    tests++;
    if ({num, sel, running, done} !== e) begin
      fails++; $display("FAIL zero_load got %h want %h", {num, sel, running, done}, e);
    end
    cancel();
    tests++;
    if ({num, sel, running, done} !== 22'h0) begin
      fails++; $display("FAIL zero_ack got %h want %h", {num, sel, running, done}, 22'h0);
    end
  endtask

  task automatic test_back_to_back_load();
    logic [21:0] e;
    load_time(16'h0002, 1'b1);
    load = 1'b0;
    step();
    time_in = 16'h9999;
    load = 1'b1;
    step();
    step();
    e = {16'h0002, 4'hF, 1'b1, 1'b0};
    tests++;
    if ({num, sel, running, done} !== e) begin
      fails++; $display("FAIL reload_ignored got %h want %h", {num, sel, running, done}, e);
    end
    step();
    e = {16'h0001, 4'hF, 1'b1, 1'b0};
    tests++;
    if ({num, sel, running, done} !== e) begin
      fails++; $display("FAIL reload_tick got %h want %h", {num, sel, running, done}, e);
    end
    cancel();
  endtask

  task automatic test_reset_mid();
    logic [21:0] e;
    load_time(16'h0030, 1'b1);
    repeat (5) step();
    resetn = 1'b0;
    step();
    tests++;
    if ({num, sel, running, done} !== 22'h0) begin
      fails++; $display("FAIL reset_mid got %h want %h", {num, sel, running, done}, 22'h0);
    end
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({num, sel, running, done} !== 22'h0) begin
        fails++; $display("FAIL held_load%0d got %h want %h", i, {num, sel, running, done}, 22'h0);
      end
    end
    load_time(16'h0030, 1'b1);
    e = {16'h0030, 4'hF, 1'b1, 1'b0};
    tests++;
    if ({num, sel, running, done} !== e) begin
      fails++; $display("FAIL reload_after_reset got %h want %h", {num, sel, running, done}, e);
    end
    cancel();
  endtask

  // Model: remaining time in plain seconds, run-cycle phase within the second.
  task automatic test_random();
    int secs, phase, st, dj, cyc;
    logic [15:0] t;
    logic [21:0] e, got;
    for (int trial = 0; trial < 6; trial++) begin
      secs = $urandom_range(1, 130);
      t = to_bcd(secs);
      st = $urandom_range(1, 2);
      load_time(t, st == 2);
      phase = 0;
      dj = 0;
      cyc = 0;
      e = {t, 4'hF, st == 2, 1'b0};
      tests++;
      if ({num, sel, running, done} !== e) begin
        fails++; $display("FAIL rnd_load%0d got %h want %h", trial, {num, sel, running, done}, e);
      end
      while (st != 0 && cyc < 3000) begin
        spdt2 = ($urandom_range(0, 9) < 7);
        push_c = (st == 3) ? (dj >= 3) : ($urandom_range(0, 399) == 0);
        if (push_c) st = 0;
        else if (st == 1) begin
          if (spdt2) st = 2;
        end else if (st == 2) begin
          if (!spdt2) st = 1;
          else begin
            phase++;
            if (phase == TPS) begin
              phase = 0;
              secs--;
              if (secs == 0) begin
                st = 3;
                dj = 0;
              end
            end
          end
        end else dj++;
        if (st == 0)      exp_q.push_back(22'h0);
        else if (st == 3) exp_q.push_back({16'h0, done_sel(dj), 1'b0, 1'b1});
        else              exp_q.push_back({to_bcd(secs), 4'hF, st == 2, 1'b0});
        step();
        push_c = 1'b0;
        got = {num, sel, running, done};
        e = exp_q.pop_front();
        tests++;
        if (got !== e) begin
          fails++; $display("FAIL rnd%0d_c%0d got %h want %h", trial, cyc, got, e);
        end
        cyc++;
      end
      tests++;
      if (st != 0) begin
        fails++; $display("FAIL rnd_timeout%0d got state %0d want 0", trial, st);
        cancel();
      end
      load = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_cancel_tick();
    test_zero_load();
    test_back_to_back_load();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
